// File: rtl/sync_fifo_stream_adapter.sv
// Bridges a 1-cycle-latency FIFO read port onto a valid/ready stream.
// Two-entry skid storage absorbs the in-flight read so throughput stays at one word per cycle.
module sync_fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_read_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [1:0]            occupancy_o
);

  logic [1:0]            occ;
  logic                  in_flight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] mem [2];

  logic                  pop;
  logic [2:0]            committed;

  // Words that will be held after this cycle: buffered plus the returning read, minus the one leaving.
  always_comb begin
    pop         = (occ != 2'd0) && m_ready_i && !rst_i;
    committed   = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    fifo_read_o = !fifo_empty_i && !rst_i && (committed < 3'd2);
  end

  assign m_valid_o   = (occ != 2'd0) && !rst_i;
  assign m_data_o    = rst_i ? '0 : mem[head];
  assign occupancy_o = rst_i ? 2'd0 : occ;

  // Reset drops any word still returning from the FIFO because in_flight is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ       <= 2'd0;
      in_flight <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      in_flight <= fifo_read_o;
      if (in_flight) begin
        mem[tail] <= fifo_rd_data_i;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= committed[1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (committed <= 3'd2);
    end
  end

endmodule

// File: tb/tb_sync_fifo_stream_adapter.sv
// Self-checking bench: behavioural upstream FIFO feeding the adapter, scoreboard on the stream side.
module tb_sync_fifo_stream_adapter;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] fifo_rd_data_i;
  logic        fifo_empty_i;
  logic        fifo_read_o;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [1:0]  occupancy_o;

  int checks;
  int failures;
  int cyc;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];

  logic g_rd;
  logic g_pop;
  logic g_valid;

  sync_fifo_stream_adapter #(.DATA_WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_read_o   (fifo_read_o),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .occupancy_o   (occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, judge the stream, then let the FIFO model respond.
  task automatic applyStimulus(input logic ready, input logic hide_empty);
    m_ready_i    = ready;
    fifo_empty_i = hide_empty || (fifo_q.size() == 0);
    #1;
    g_rd    = fifo_read_o;
    g_valid = m_valid_o;
    g_pop   = m_valid_o && m_ready_i;
    checkOutput("read_while_empty", 32'(g_rd && fifo_empty_i), 32'd0);
    checkOutput("occ_le_2", 32'(occupancy_o <= 2'd2), 32'd1);
    checkOutput("valid_vs_occ", 32'(m_valid_o), 32'(occupancy_o != 2'd0));
    if (g_pop) begin
      checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        checkOutput("sb_data", m_data_o, exp_q.pop_front());
      end
    end
    @(posedge clk_i);
    #1;
    if (g_rd && fifo_q.size() != 0) begin
      fifo_rd_data_i = fifo_q.pop_front();
    end else begin
      fifo_rd_data_i = $urandom;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_i        = 1'b1;
      fifo_empty_i = 1'b0;
      m_ready_i    = 1'b1;
      #1;
      checkOutput("rst_read", 32'(fifo_read_o), 32'd0);
      checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
      checkOutput("rst_data", m_data_o, 32'd0);
      checkOutput("rst_occ", 32'(occupancy_o), 32'd0);
      @(negedge clk_i);
      cyc++;
    end
    rst_i = 1'b0;
  endtask

  initial begin
    int first_rd, first_valid, first_pop, last_pop, npop, nrd;
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    rst_i          = 1'b1;
    fifo_empty_i   = 1'b0;
    m_ready_i      = 1'b0;
    fifo_rd_data_i = '0;
    @(negedge clk_i);

    holdReset(2);

    // Streaming with the consumer always ready.
    for (int w = 1; w <= 8; w++) begin
      fifo_q.push_back(32'(w));
      exp_q.push_back(32'(w));
    end
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1; npop = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (g_rd && first_rd < 0) first_rd = i;
      if (g_valid && first_valid < 0) first_valid = i;
      if (g_pop) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        npop++;
      end
    end
    checkOutput("st_latency", 32'(first_valid), 32'(first_rd + 2));
    checkOutput("st_count", 32'(npop), 32'd8);
    checkOutput("st_back_to_back", 32'(last_pop - first_pop), 32'd7);
    checkOutput("st_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalled, buffer must fill to two and hold.
    fifo_q.push_back(32'hA); fifo_q.push_back(32'hB); fifo_q.push_back(32'hC);
    exp_q.push_back(32'hA);  exp_q.push_back(32'hB);  exp_q.push_back(32'hC);
    nrd = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (g_rd) nrd++;
      if (i >= 3) begin
        checkOutput("bp_hold_data", m_data_o, 32'hA);
        checkOutput("bp_hold_valid", 32'(m_valid_o), 32'd1);
      end
    end
    checkOutput("bp_reads", 32'(nrd), 32'd2);
    checkOutput("bp_occ", 32'(occupancy_o), 32'd2);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("bp_idle_valid", 32'(m_valid_o), 32'd0);

    // Empty flag flickering every cycle with random consumer readiness.
    for (int w = 0; w < 600; w++) begin
      logic [31:0] v;
      v = $urandom;
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    for (int i = 0; i < 1000; i++) applyStimulus(1'($urandom_range(0, 1)), 1'(i % 2));
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tg_sb_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("tg_fifo_empty", 32'(fifo_q.size()), 32'd0);
    checkOutput("tg_idle_valid", 32'(m_valid_o), 32'd0);

    // Reset arriving while a read is in flight with one word buffered.
    fifo_q.push_back(32'h1111_0001);
    exp_q.push_back(32'h1111_0001);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mf_occ_before", 32'(occupancy_o), 32'd1);
    fifo_q.push_back(32'h2222_0002);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mf_read_issued", 32'(g_rd), 32'd1);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst_i = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    checkOutput("mf_occ_after", 32'(occupancy_o), 32'd0);
    checkOutput("mf_valid_after", 32'(m_valid_o), 32'd0);
    npop = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (g_pop) npop++;
    end
    checkOutput("mf_no_output", 32'(npop), 32'd0);

    // Drain: buffer full, FIFO exhausted, consumer released.
    fifo_q.push_back(32'hD1); fifo_q.push_back(32'hD2);
    exp_q.push_back(32'hD1);  exp_q.push_back(32'hD2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("dr_occ_full", 32'(occupancy_o), 32'd2);
    checkOutput("dr_fifo_empty", 32'(fifo_q.size()), 32'd0);
    npop = 0; nrd = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (g_pop) npop++;
      if (g_rd) nrd++;
    end
    checkOutput("dr_pops", 32'(npop), 32'd2);
    checkOutput("dr_reads", 32'(nrd), 32'd0);
    checkOutput("dr_valid_low", 32'(m_valid_o), 32'd0);
    checkOutput("dr_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_stream_adapter.md
SYNC_FIFO_STREAM_ADAPTER -- requirements
Module: sync_fifo_stream_adapter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 fifo_rd_data_i  input  DATA_WIDTH  read data from the upstream sync FIFO, valid the cycle after a read is issued.
REQ-005 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-006 fifo_read_o  output  1  read request to the upstream FIFO.
REQ-007 m_data_o  output  DATA_WIDTH  stream data to the consumer.
REQ-008 m_valid_o  output  1  stream data valid.
REQ-009 m_ready_i  input  1  consumer ready.
REQ-010 occupancy_o  output  2  number of words held in the output buffer (0..2).

Function
REQ-011 The block SHALL convert the FIFO read/empty protocol (1-cycle read latency) into a valid/ready stream, holding at most 2 buffered words plus 1 in-flight read.
REQ-012 State: occ (0..2), in_flight (1 bit, set the cycle after fifo_read_o=1), 2-entry storage with head/tail pointers of 1 bit each.
REQ-013 pop SHALL be m_valid_o && m_ready_i; m_valid_o SHALL equal (occ != 0).
REQ-014 fifo_read_o SHALL be !fifo_empty_i && !rst_i && (occ + in_flight - pop) < 2; combinational path from m_ready_i to fifo_read_o is permitted.
REQ-015 in_flight SHALL be registered fifo_read_o; when in_flight=1, fifo_rd_data_i SHALL be written at tail and tail SHALL toggle.
REQ-016 On pop, head SHALL toggle; m_data_o SHALL always present the head entry.
REQ-017 occ next = occ + in_flight - pop; simultaneous push and pop SHALL leave occ unchanged.
REQ-018 Word order on m_data_o SHALL equal FIFO read order; no word SHALL be dropped or duplicated.
REQ-019 m_data_o and m_valid_o SHALL remain stable while m_valid_o=1 and m_ready_i=0.
REQ-020 With m_ready_i held 1 and FIFO non-empty, throughput SHALL be 1 word per cycle after a 2-cycle startup (read issue -> data captured -> m_valid_o).
REQ-021 First-word latency: fifo_read_o in cycle N SHALL give m_valid_o=1 in cycle N+2.
REQ-022 With occ=2 and no pop, fifo_read_o SHALL be 0 regardless of fifo_empty_i.
REQ-023 occupancy_o SHALL equal occ; occ SHALL never exceed 2 (overflow is a design error, flagged by assertion).
REQ-024 fifo_empty_i transitions SHALL affect only the read decision of the same cycle; an already in-flight read SHALL complete normally.

Reset
REQ-025 While rst_i=1: occ=0, in_flight=0, head=tail=0, m_valid_o=0, m_data_o=0, occupancy_o=0, fifo_read_o=0.
REQ-026 Reset asserted with a read in flight SHALL discard the returning word; the upstream FIFO is reset by its own reset and is not controlled by this block.
REQ-027 First fifo_read_o after reset SHALL occur no earlier than the first cycle with rst_i=0.

Verification
REQ-028 Reset: rst_i=1 for 2 cycles with fifo_empty_i=0 -> fifo_read_o=0, m_valid_o=0, m_data_o=0, occupancy_o=0 throughout.
REQ-029 Streaming: FIFO holds 0x1..0x8, m_ready_i=1 -> m_data_o sequence 0x1..0x8 on 8 consecutive cycles, m_valid_o first high 2 cycles after first read.
REQ-030 Backpressure: FIFO holds 0xA,0xB,0xC, m_ready_i=0 -> exactly 2 reads issued, occupancy_o=2, m_data_o=0xA stable; release m_ready_i -> 0xA,0xB,0xC in order.
REQ-031 Empty toggle: fifo_empty_i toggles every cycle, random m_ready_i for 1000 cycles -> scoreboard shows no loss, duplication or reorder, occ never >2.
REQ-032 Reset mid-flight: rst_i=1 the cycle after a read with occ=1 -> next cycle occupancy_o=0, m_valid_o=0, returning word not output.
REQ-033 Drain: FIFO goes empty with occ=2, m_ready_i=1 -> 2 more words output, then m_valid_o=0 and fifo_read_o=0.
